// File: rtl/mem_access_unit.sv
// Load/store sequencer for a 16-bit word-organised data memory; byte stores use read-modify-write.
// Optional build macro MEM_ACCESS_SIGNED_LOAD_EN adds req_signed for sign-extended byte loads.
module mem_access_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef MEM_ACCESS_SIGNED_LOAD_EN
  input  logic              req_signed,
`endif
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RMW_RD,
    S_WR,
    S_RESP
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic              r_byte;
  logic [7:0]        r_wdata_lo;
  logic [DATA_W-1:0] r_wr_data;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic              w_accept;
  logic              w_misalign;
  logic [7:0]        w_sel_byte;
  logic              w_sign;
  logic [DATA_W-1:0] w_load;
  logic [DATA_W-1:0] w_merged;

  assign w_accept   = req_valid && (r_state == S_IDLE);
  assign w_misalign = !req_byte && req_addr[0];

  // Little-endian lanes: address bit 0 picks the high byte.
  assign w_sel_byte = r_addr[0] ? mem_read_data[15:8] : mem_read_data[7:0];

`ifdef MEM_ACCESS_SIGNED_LOAD_EN
  logic r_signed;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_signed <= 1'b0;
    end else if (w_accept) begin
      r_signed <= req_signed;
    end
  end

  assign w_sign = r_signed & w_sel_byte[7];
`else
  assign w_sign = 1'b0;
`endif

  assign w_load   = r_byte ? {{8{w_sign}}, w_sel_byte} : mem_read_data;
  assign w_merged = r_addr[0] ? {r_wdata_lo, mem_read_data[7:0]}
                              : {mem_read_data[15:8], r_wdata_lo};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    req_ready    = 1'b0;
    mem_read     = 1'b0;
    mem_write_en = 1'b0;
    resp_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (w_accept) begin
          if (w_misalign)      w_next = S_RESP;
          else if (!req_write) w_next = S_RD;
          else if (!req_byte)  w_next = S_WR;
          else                 w_next = S_RMW_RD;
        end
      end
      S_RD: begin
        mem_read = 1'b1;
        w_next   = S_RESP;
      end
      S_RMW_RD: begin
        mem_read = 1'b1;
        w_next   = S_WR;
      end
      S_WR: begin
        mem_write_en = 1'b1;
        w_next       = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr     <= '0;
      r_byte     <= 1'b0;
      r_wdata_lo <= '0;
      r_wr_data  <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr     <= req_addr;
            r_byte     <= req_byte;
            r_wdata_lo <= req_wdata[7:0];
            r_err      <= w_misalign;
            // Stores and errors respond with zero data.
            if (req_write || w_misalign) r_rdata <= '0;
            if (req_write && !req_byte && !w_misalign) r_wr_data <= req_wdata;
          end
        end
        S_RD:     r_rdata   <= w_load;
        S_RMW_RD: r_wr_data <= w_merged;
        S_RESP:   r_err     <= 1'b0;
        default: ;
      endcase
    end
  end

  assign mem_access_addr = (r_state == S_IDLE) ? '0 : {r_addr[ADDR_W-1:1], 1'b0};
  assign mem_write_data  = r_wr_data;
  assign resp_rdata      = r_rdata;
  assign resp_err        = r_err;

endmodule
